// File: rtl/bootrom_frontend.sv
// Boot mask ROM request/response front end: single outstanding Get, ROM me/oe/address drive, registered response.
// Optional legality checking (opcode, size, alignment, address window) is enabled by BOOTROM_FRONTEND_CHECK_EN.
module bootrom_frontend #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int unsigned ROM_WORDS = 2048
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [31:0] a_address,
    input  logic [1:0]  a_size,
    input  logic [3:0]  a_source,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_data,
    output logic [1:0]  d_size,
    output logic [3:0]  d_source,
    output logic        d_denied,
    output logic        rom_me,
    output logic        rom_oe,
    output logic [10:0] rom_address,
    input  logic [31:0] rom_q
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_RESP
    } state_t;

    state_t      r_state;
    logic        r_d_valid;
    logic [31:0] r_d_data;
    logic [1:0]  r_d_size;
    logic [3:0]  r_d_source;
    logic        r_d_denied;
    logic [10:0] r_rom_addr;

    logic        w_a_fire;
    logic        w_legal;
    logic [10:0] w_req_addr;
    logic        w_unused;

    assign a_ready  = (r_state == ST_IDLE) && !reset;
    assign w_a_fire = a_valid && a_ready && !reset;

`ifdef BOOTROM_FRONTEND_CHECK_EN
    // Window bounds in 33 bits so a window touching 2^32 cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(ROM_WORDS) << 2);

    logic [32:0] w_addr33;
    logic [31:0] w_offset;
    logic        w_aligned;

    assign w_addr33 = {1'b0, a_address};

    always_comb begin
        w_aligned = 1'b1;
        case (a_size)
            2'd1:    w_aligned = !a_address[0];
            2'd2:    w_aligned = (a_address[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_legal    = (a_opcode == 3'd4) && (a_size != 2'd3) && w_aligned &&
                        (w_addr33 >= WIN_LO) && (w_addr33 < WIN_HI);
    assign w_offset   = a_address - BASE_ADDR;
    assign w_req_addr = w_offset[12:2];
    assign w_unused   = ^{w_offset[31:13], w_offset[1:0]};
`else
    assign w_legal    = 1'b1;
    assign w_req_addr = a_address[12:2];
    assign w_unused   = ^{a_opcode, a_address[31:13], a_address[1:0], BASE_ADDR, ROM_WORDS};
`endif

    assign rom_me      = w_a_fire && w_legal;
    assign rom_address = rom_me ? w_req_addr : r_rom_addr;
    assign rom_oe      = (r_state == ST_READ);

    assign d_valid  = r_d_valid;
    assign d_data   = r_d_data;
    assign d_size   = r_d_size;
    assign d_source = r_d_source;
    assign d_denied = r_d_denied;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_d_valid  <= 1'b0;
            r_d_data   <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_denied <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_a_fire) begin
                        r_d_size   <= a_size;
                        r_d_source <= a_source;
                        if (w_legal) begin
                            r_rom_addr <= w_req_addr;
                            r_state    <= ST_READ;
                        end else begin
                            r_d_data   <= '0;
                            r_d_denied <= 1'b1;
                            r_d_valid  <= 1'b1;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_READ: begin
                    r_d_data   <= rom_q;
                    r_d_denied <= 1'b0;
                    r_d_valid  <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (d_ready) begin
                        r_d_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bootrom_frontend.sv
// Scoreboard bench for bootrom_frontend with a registered ROM model; follows BOOTROM_FRONTEND_CHECK_EN.
module tb_bootrom_frontend;

    localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef BOOTROM_FRONTEND_CHECK_EN
    localparam bit CHECKED = 1'b1;
`else
    localparam bit CHECKED = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [31:0] a_address;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_data;
    logic [1:0]  d_size;
    logic [3:0]  d_source;
    logic        d_denied;
    logic        rom_me;
    logic        rom_oe;
    logic [10:0] rom_address;
    logic [31:0] rom_q = '0;

    always #5 clock = ~clock;

    bootrom_frontend #(.BASE_ADDR(BASE), .ROM_WORDS(2048)) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_address(a_address), .a_size(a_size), .a_source(a_source),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
        .d_size(d_size), .d_source(d_source), .d_denied(d_denied),
        .rom_me(rom_me), .rom_oe(rom_oe), .rom_address(rom_address), .rom_q(rom_q)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  size;
        logic [3:0]  source;
        logic        denied;
    } resp_t;

    resp_t       sb[$];
    resp_t       mon_e;
    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] mem [0:2047];

    function automatic logic [31:0] rom_word(input logic [31:0] i);
        if (i == 32'd2)    return 32'hDEAD_BEEF;
        if (i == 32'd1)    return 32'h1111_0001;
        if (i == 32'd2047) return 32'hCAFE_07FF;
        return {i[15:0] ^ 16'h5A5A, ~i[15:0]};
    endfunction

    function automatic bit exp_legal(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size);
        logic [32:0] a;
        bit          al;
        bit          chk;
        a   = {1'b0, addr};
        al  = (size == 2'd2) ? (addr[1:0] == 2'b00) : (size == 2'd1) ? !addr[0] : 1'b1;
        chk = (op == 3'd4) && (size != 2'd3) && al && (a >= 33'h0_0001_0000) && (a < 33'h0_0001_2000);
        return CHECKED ? chk : 1'b1;
    endfunction

    function automatic logic [10:0] exp_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - 32'h0001_0000;
        return CHECKED ? off[12:2] : addr[12:2];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Registered ROM: q is valid the cycle after me.
    always @(posedge clock) if (rom_me) rom_q <= mem[rom_address];

    always @(negedge clock) begin
        if (!reset && d_valid && d_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_data", d_data, mon_e.data);
                check("resp_size", {30'd0, d_size}, {30'd0, mon_e.size});
                check("resp_source", {28'd0, d_source}, {28'd0, mon_e.source});
                check("resp_denied", {31'd0, d_denied}, {31'd0, mon_e.denied});
            end
        end
    end

    task automatic scramble();
        a_opcode  = 3'($urandom);
        a_address = $urandom;
        a_size    = 2'($urandom);
        a_source  = 4'($urandom);
    endtask

    task automatic req(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] size,
                       input logic [3:0] src, input int unsigned delay, input bit noise);
        bit          legal;
        logic [10:0] idx;
        resp_t       e;
        int unsigned lat;
        legal    = exp_legal(op, addr, size);
        idx      = exp_index(addr);
        e.data   = legal ? mem[idx] : '0;
        e.size   = size;
        e.source = src;
        e.denied = !legal;
        lat      = legal ? 2 : 1;
        @(posedge clock); #1;
        a_valid = 1'b1; a_opcode = op; a_address = addr; a_size = size; a_source = src;
        d_ready = 1'b0;
        @(negedge clock);
        check("a_ready_idle", {31'd0, a_ready}, 32'd1);
        check("rom_me_acc", {31'd0, rom_me}, {31'd0, legal});
        check("d_valid_acc", {31'd0, d_valid}, 32'd0);
        if (legal) check("rom_addr", {21'd0, rom_address}, {21'd0, idx});
        sb.push_back(e);
        for (int unsigned k = 1; k <= lat + delay; k++) begin
            @(posedge clock); #1;
            scramble();
            a_valid = noise && (k < lat + delay);
            d_ready = (k == lat + delay);
            @(negedge clock);
            check("a_ready_busy", {31'd0, a_ready}, 32'd0);
            check("rom_me_busy", {31'd0, rom_me}, 32'd0);
            check("rom_oe", {31'd0, rom_oe}, {31'd0, legal && (k == 1)});
            check("d_valid", {31'd0, d_valid}, {31'd0, k >= lat});
            if (k >= lat) begin
                check("d_data_hold", d_data, e.data);
                check("d_denied_hold", {31'd0, d_denied}, {31'd0, e.denied});
                check("d_source_hold", {28'd0, d_source}, {28'd0, src});
            end
        end
    endtask

    initial begin
        for (int unsigned i = 0; i < 2048; i++) mem[i] = rom_word(i);
        reset = 1'b1; a_valid = 1'b1; a_opcode = 3'd4; a_address = BASE + 32'h8;
        a_size = 2'd2; a_source = 4'd5; d_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("a_ready_rst", {31'd0, a_ready}, 32'd0);
        check("rom_me_rst", {31'd0, rom_me}, 32'd0);
        check("rom_oe_rst", {31'd0, rom_oe}, 32'd0);
        check("d_valid_rst", {31'd0, d_valid}, 32'd0);
        check("d_data_rst", d_data, 32'd0);
        check("d_size_rst", {30'd0, d_size}, 32'd0);
        check("d_source_rst", {28'd0, d_source}, 32'd0);
        check("d_denied_rst", {31'd0, d_denied}, 32'd0);
        check("rom_addr_rst", {21'd0, rom_address}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; a_valid = 1'b0;
        @(negedge clock);
        check("a_ready_after_rst", {31'd0, a_ready}, 32'd1);

        // Basic read, then back-to-back with a stalled response and noisy a_valid.
        req(3'd4, BASE + 32'h8, 2'd2, 4'd5, 0, 1'b0);
        req(3'd4, BASE + 32'h8, 2'd2, 4'd5, 4, 1'b1);
        req(3'd4, BASE + 32'h1FFC, 2'd2, 4'd9, 0, 1'b0);
        req(3'd4, BASE + 32'h6, 2'd1, 4'd2, 1, 1'b0);
        req(3'd4, BASE + 32'h3, 2'd0, 4'd3, 0, 1'b0);
        // Illegal under legality checking; plain reads otherwise.
        req(3'd4, BASE + 32'h2000, 2'd2, 4'd1, 0, 1'b0);
        req(3'd4, BASE + 32'h2, 2'd2, 4'd4, 2, 1'b0);
        req(3'd0, BASE + 32'h10, 2'd2, 4'd6, 0, 1'b0);
        req(3'd4, BASE + 32'h1, 2'd1, 4'd7, 0, 1'b0);
        req(3'd4, BASE + 32'h10, 2'd3, 4'd8, 1, 1'b0);
        req(3'd4, BASE - 32'h4, 2'd2, 4'd10, 0, 1'b0);
        req(3'd0, 32'h0000_0004, 2'd2, 4'd11, 0, 1'b0);

        // Reset while in READ: response dropped.
        @(posedge clock); #1;
        a_valid = 1'b1; a_opcode = 3'd4; a_address = BASE + 32'h40; a_size = 2'd2; a_source = 4'd12;
        d_ready = 1'b1;
        @(negedge clock);
        check("rom_me_pre_rst", {31'd0, rom_me}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rom_me_in_rst", {31'd0, rom_me}, 32'd0);
        check("a_ready_in_rst", {31'd0, a_ready}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; a_valid = 1'b0;
        @(negedge clock);
        check("d_valid_after_rst_read", {31'd0, d_valid}, 32'd0);
        check("a_ready_after_rst_read", {31'd0, a_ready}, 32'd1);
        repeat (2) begin
            @(negedge clock);
            check("no_resp_after_rst", {31'd0, d_valid}, 32'd0);
        end

        // Reset while in RESP with response pending.
        @(posedge clock); #1;
        a_valid = 1'b1; a_opcode = 3'd4; a_address = BASE + 32'h44; a_size = 2'd2; a_source = 4'd13;
        d_ready = 1'b0;
        @(posedge clock); #1;
        a_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("d_valid_pre_rst_resp", {31'd0, d_valid}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("d_valid_after_rst_resp", {31'd0, d_valid}, 32'd0);

        req(3'd4, BASE + 32'h8, 2'd2, 4'd5, 0, 1'b0);

        for (int unsigned n = 0; n < 24; n++) begin
            logic [31:0] ra;
            ra = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'($urandom_range(0, 8191));
            req(($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd4, ra, 2'($urandom),
                4'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        repeat (4) @(negedge clock);
        check("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bootrom_frontend.md
# bootrom_frontend

Request/response front end for the boot mask ROM. It accepts single-beat read requests from the peripheral bus, translates byte addresses into 11-bit ROM word indices, and drives the ROM's `me`/`oe`/`address` pins. It captures the ROM's registered 32-bit output and returns it on a valid/ready response channel. Illegal accesses are answered with a denied response and never reach the ROM.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0001_0000: byte address of ROM word 0.
- `ROM_WORDS`, default 2048: ROM depth in 32-bit words; the address window is `ROM_WORDS*4` bytes.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  request valid.
- `a_ready`  out  1  request ready.
- `a_opcode`  in  3  request opcode; 3'd4 is Get, all other values are illegal.
- `a_address`  in  32  byte address.
- `a_size`  in  2  log2 of bytes: 0, 1 or 2; 3 is illegal.
- `a_source`  in  4  requester tag.
- `d_valid`  out  1  response valid.
- `d_ready`  in  1  response ready.
- `d_data`  out  32  full ROM word; byte lanes are not shifted.
- `d_size`  out  2  echo of `a_size`.
- `d_source`  out  4  echo of `a_source`.
- `d_denied`  out  1  request was illegal; `d_data` is 0.
- `rom_me`  out  1  to ROM `me`.
- `rom_oe`  out  1  to ROM `oe`.
- `rom_address`  out  11  to ROM `address`.
- `rom_q`  in  32  from ROM `q`; valid the cycle after `rom_me`.

## Operation
- FSM states:
  - IDLE: `a_ready`=1.
  - READ: waiting for `rom_q`.
  - RESP: `d_valid`=1.
- Accept: `a_fire = a_valid & a_ready & ~reset`. On `a_fire`, latch `a_size` and `a_source` into the response registers and evaluate legality.
- Legal request:
  - Conditions: opcode is Get, size ≤ 2, address aligned to size, and `BASE_ADDR ≤ a_address < BASE_ADDR + ROM_WORDS*4`. Compute the window end with 33-bit arithmetic so the comparison cannot wrap.
  - In the same cycle: `rom_me`=1 (combinational from `a_fire`), `rom_address = (a_address - BASE_ADDR) >> 2`, truncated to 11 bits.
  - Next state is READ.
- Illegal request: `rom_me` stays 0, the data register is loaded with 0, `d_denied` is set, and next state is RESP.
- READ: `rom_oe`=1. The data register captures `rom_q` with `d_denied`=0, and next state is RESP.
- RESP: hold `d_valid`, `d_data`, `d_size`, `d_source` and `d_denied` stable until `d_valid & d_ready`, then go to IDLE.
- Only one request is outstanding at a time. `a_ready`=0 in READ and RESP.
- `rom_oe` is 0 outside READ, so the ROM bus is high-Z.
- `rom_address` holds its last value when `rom_me`=0.

## Timing
- Reset values: `a_ready`=0 while `reset` is high and 1 in the first cycle after it. `d_valid`=0, `d_data`=0, `d_size`=0, `d_source`=0, `d_denied`=0, `rom_me`=0, `rom_oe`=0, `rom_address`=0. State is IDLE.
- Legal read: accepted in cycle N, `rom_me` high in N, `rom_q` sampled in N+1, `d_valid` high from N+2. Minimum initiation interval is 3 cycles, with `d_ready` held high.
- Denied request: accepted in N, `d_valid` from N+1.
- `d_ready` high in the first RESP cycle: the response completes that cycle and `a_ready` is 1 the next cycle. There is no same-cycle IDLE bypass.
- Reset asserted in READ or RESP: the in-flight response is dropped and `d_valid` is 0 the cycle after. `rom_me` is forced to 0 during reset.
- `a_valid` may drop without acceptance; no request is latched unless `a_fire`.

## Configuration
- `BOOTROM_FRONTEND_CHECK_EN` defined: full legality checking as described above.
- `BOOTROM_FRONTEND_CHECK_EN` undefined:
  - Every accepted request is treated as a legal Get.
  - `rom_address = a_address[12:2]`; `BASE_ADDR` is ignored.
  - `d_denied` is tied to 0.
  - Latency is always the legal-read path.

## Test plan
- Reset, then Get at 0x0001_0008, size 2, source 5, ROM word 2 = 0xDEAD_BEEF, `d_ready`=1 -> `rom_me` and `rom_address`=2 in N; `d_valid` in N+2 with data 0xDEAD_BEEF, source 5, denied 0; `a_ready` is 1 at N+3.
- Same read with `d_ready` held low 4 cycles -> response stable for 5 cycles, `a_ready`=0 throughout, completes on the first cycle `d_ready`=1.
- With CHECK_EN: address 0x0001_2000 (one past end), then 0x0001_0002 at size 2, then opcode 0 (Put) -> each gives `d_valid` at N+1 with `d_denied`=1 and `d_data`=0, and `rom_me` never asserted.
- Last word 0x0001_1FFC -> `rom_address`=2047 and the correct data is returned.
- Reset asserted during READ -> no response appears, `d_valid`=0, and the next request after reset is served normally.
- CHECK_EN undefined: address 0x0000_0004 with opcode Put -> `rom_address`=1, ROM word 1 returned, `d_denied`=0.
